// File: rtl/shift8_seq.sv
// Multi-pass sequencer driving an external combinational 8-bit LSL shifter.
// Splits a 0-7 shift into passes of at most 3 positions and accumulates the result.
module shift8_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] d_in,
    input  logic [2:0] amt,
    output logic       busy,
    output logic       done,
    output logic [7:0] d_out,
    output logic [7:0] lsl_d_in,
    output logic [1:0] lsl_shamt,
    input  logic [7:0] lsl_d_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] acc;
    logic [2:0] rem;
    logic [1:0] step;
    logic [2:0] rem_next;

    // NOTE: every signal driven here is fully assigned on every path, so no latch can form.
    always_comb begin
        step     = (rem >= 3'd3) ? 2'd3 : rem[1:0];
        rem_next = rem - {1'b0, step};
    end

    assign lsl_shamt = (state == SHIFT) ? step : 2'b00;
    assign lsl_d_in  = acc;
    assign d_out     = acc;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // NOTE: non-blocking assignments so all registers update from pre-edge values together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= 8'h00;
            rem   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= d_in;
                        rem   <= amt;
                        state <= (amt != 3'd0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    acc <= lsl_d_out;
                    rem <= rem_next;
                    if (rem_next == 3'd0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift8_seq.sv
// Self-checking bench for shift8_seq: directed scenarios plus random requests
// compared cycle by cycle against a pass-list reference model.
module tb_shift8_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] d_in;
    logic [2:0] amt;
    logic       busy;
    logic       done;
    logic [7:0] d_out;
    logic [7:0] lsl_d_in;
    logic [1:0] lsl_shamt;
    logic [7:0] lsl_d_out;

    int checks = 0;
    int errors = 0;

    shift8_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .d_in      (d_in),
        .amt       (amt),
        .busy      (busy),
        .done      (done),
        .d_out     (d_out),
        .lsl_d_in  (lsl_d_in),
        .lsl_shamt (lsl_shamt),
        .lsl_d_out (lsl_d_out)
    );

    // The external LSL8 shifter: purely combinational.
    assign lsl_d_out = lsl_d_in << lsl_shamt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [7:0] exp_dout);
        check({tag, " busy"}, {7'd0, busy}, 8'd0);
        check({tag, " done"}, {7'd0, done}, 8'd0);
        check({tag, " d_out"}, d_out, exp_dout);
        check({tag, " shamt"}, {6'd0, lsl_shamt}, 8'd0);
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge after done
    // has fallen. With poke set, an ignored start (FF, amt 1) is held during SHIFT/DONE.
    task automatic run_req(input logic [7:0] d, input logic [2:0] a, input bit poke);
        int passes;
        int steps[3];
        int left;
        int cum;
        logic [7:0] result;

        passes = 0;
        left   = a;
        while (left > 0) begin
            steps[passes] = (left > 3) ? 3 : left;
            left          = left - steps[passes];
            passes++;
        end
        result = 8'((16'(d) << a));

        start = 1'b1;
        d_in  = d;
        amt   = a;
        @(negedge clk);
        cum = 0;
        for (int k = 0; k <= passes + 1; k++) begin
            if (k < passes) begin
                check($sformatf("req %0h<<%0d pass%0d busy", d, a, k), {7'd0, busy}, 8'd1);
                check($sformatf("req %0h<<%0d pass%0d done", d, a, k), {7'd0, done}, 8'd0);
                check($sformatf("req %0h<<%0d pass%0d shamt", d, a, k), {6'd0, lsl_shamt}, 8'(steps[k]));
                check($sformatf("req %0h<<%0d pass%0d acc", d, a, k), d_out, 8'((16'(d) << cum)));
                cum += steps[k];
            end else if (k == passes) begin
                check($sformatf("req %0h<<%0d done busy", d, a), {7'd0, busy}, 8'd1);
                check($sformatf("req %0h<<%0d done strobe", d, a), {7'd0, done}, 8'd1);
                check($sformatf("req %0h<<%0d done shamt", d, a), {6'd0, lsl_shamt}, 8'd0);
                check($sformatf("req %0h<<%0d result", d, a), d_out, result);
            end else begin
                check_idle_outputs($sformatf("req %0h<<%0d after", d, a), result);
            end
            if (k <= passes && poke) begin
                start = 1'b1;
                d_in  = 8'hFF;
                amt   = 3'd1;
            end else begin
                start = 1'b0;
            end
            if (k <= passes) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        d_in  = 8'h00;
        amt   = 3'd0;

        // Reset with random start activity: nothing may be accepted.
        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom_range(0, 1));
            d_in  = 8'($urandom);
            amt   = 3'($urandom);
            @(negedge clk);
            check_idle_outputs($sformatf("reset cyc%0d", i), 8'h00);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("post reset", 8'h00);

        // Directed scenarios.
        run_req(8'hA5, 3'd0, 1'b0);
        run_req(8'h0F, 3'd5, 1'b0);
        run_req(8'hB5, 3'd7, 1'b0);
        run_req(8'h01, 3'd3, 1'b1);
        run_req(8'h3C, 3'd2, 1'b0);
        @(negedge clk);
        check_idle_outputs("result held in idle", 8'hF0);

        // Asynchronous abort after E1 of an amt=6 request.
        start = 1'b1;
        d_in  = 8'hFF;
        amt   = 3'd6;
        @(negedge clk);
        start = 1'b0;
        check("abort pass0 shamt", {6'd0, lsl_shamt}, 8'd3);
        @(negedge clk);
        check("abort pass1 acc", d_out, 8'hF8);
        #2 reset = 1'b1;
        #1 check_idle_outputs("abort immediate", 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs($sformatf("abort hold%0d", i), 8'h00);
        end
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort released", 8'h00);
        run_req(8'($urandom), 3'd2, 1'b0);

        // Random requests, occasionally with ignored start pulses.
        for (int i = 0; i < 40; i++) begin
            run_req(8'($urandom), 3'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift8_seq.md
# shift8_seq

Multi-pass sequencer for the 8-bit 4:1-mux logical-left shifter (`LSL8`). It accepts a shift request with a 3-bit amount (0–7) and holds the operand in an accumulator register. It then splits the amount into passes of at most 3 positions, drives the shifter's `d_in`/`shamt` each pass, and captures the shifter's `d_out` back into the accumulator. The shifter stays purely combinational; this block supplies its operand and consumes its result. Together they give an LSL by 0–7 with a done strobe.

## Interface
- No parameters; the datapath is fixed at 8 bits, shifter `shamt` at 2 bits, and request amount at 3 bits.
- clk  input  1  — single clock, rising edge.
- reset  input  1  — asynchronous, active-high reset.
- start  input  1  — request strobe; sampled on the clk rising edge.
- d_in  input  8  — operand; sampled with start.
- amt  input  3  — total left-shift amount, 0–7; sampled with start.
- busy  output  1  — high while a request is in progress (SHIFT or DONE state).
- done  output  1  — one-cycle strobe; d_out is valid while done is high.
- d_out  output  8  — accumulator contents, i.e. the result after done.
- lsl_d_in  output  8  — to shifter `d_in`; always equals the accumulator.
- lsl_shamt  output  2  — to shifter `shamt`; the pass amount in SHIFT, 2'b00 otherwise.
- lsl_d_out  input  8  — from shifter `d_out`; combinational function of lsl_d_in and lsl_shamt.

## Operation
- Internal registers: `acc[7:0]`, `rem[2:0]`, and a state register with states IDLE, SHIFT, DONE.
- Reset behaviour:
  - On reset high, immediately: state=IDLE, acc=8'h00, rem=3'd0.
  - Outputs under reset: busy=0, done=0, d_out=8'h00, lsl_shamt=2'b00.
- IDLE:
  - start=1 loads acc<=d_in and rem<=amt.
  - The next state is SHIFT if amt≠0, otherwise DONE.
  - start=0 leaves state and registers unchanged.
- SHIFT:
  - Pass amount `step` = 3 if rem≥3, else rem[1:0]; lsl_shamt=step.
  - Each edge: acc<=lsl_d_out and rem<=rem−step.
  - The state moves to DONE when rem−step==0, otherwise it stays in SHIFT.
- DONE:
  - done=1 for exactly one cycle.
  - The next state is IDLE unconditionally.
- start is ignored in SHIFT and DONE. The request is not queued, and acc and rem are not disturbed.
- d_out=acc in every state:
  - It holds the last result through IDLE until the next accepted start.
  - It is also visible, but not meaningful, during SHIFT.
- Arithmetic:
  - Bits shifted out past bit 7 are discarded, and zeros fill from bit 0.
  - The final result equals (d_in << amt) truncated to 8 bits.
- Pass decomposition:
  - amt 1–3 takes 1 pass; 4–6 takes 2 passes (3 + remainder); 7 takes 3 passes (3, 3, 1).
- Reset asserted mid-operation aborts the request immediately. No done is produced for the aborted request.

## Timing
- Let E0 be the edge that samples start in IDLE, and let P be the pass count: 0 for amt=0, 1 for 1–3, 2 for 4–6, 3 for 7.
- busy rises after E0 and falls after edge E(P+1).
- done is high in the cycle between E(P) and E(P+1).
  - Latency from start to done is P+1 edges, i.e. 1 to 4 cycles.
- The next start is accepted at edge E(P+2) at the earliest, so sustained throughput is one request per P+2 cycles.
- lsl_shamt is combinational from state and rem; it is stable from just after each edge.
- The shifter path lsl_d_in→lsl_d_out must settle within one clock period.
- All outputs except lsl_shamt are registered or derived directly from registered state.
  - busy = state≠IDLE; done = state==DONE.

## Test plan
- Reset, with start toggling randomly during reset: busy=0, done=0, d_out=8'h00, lsl_shamt=0 throughout. No request is accepted while reset is high.
- d_in=8'hA5, amt=0: done is high in the cycle after E0, with d_out=8'hA5. The state never enters SHIFT and lsl_shamt stays 0.
- d_in=8'h0F, amt=5: two passes, lsl_shamt=3 then 2. The accumulator goes 8'h78 then 8'hE0. done is high after E2 with d_out=8'hE0.
- d_in=8'hB5, amt=7: three passes, lsl_shamt=3,3,1. The accumulator goes A8, 40, 80. done is high after E3 with d_out=8'h80, and busy is high for 4 cycles.
- Request d_in=8'h01, amt=3, then start with d_in=8'hFF, amt=1 pulsed during SHIFT and again during DONE:
  - Both pulses are ignored, and done is high after E1 with d_out=8'h08.
  - A start pulsed in the following IDLE cycle is accepted.
- Request d_in=8'hFF, amt=6 with reset asserted asynchronously between edges after E1:
  - State goes to IDLE and d_out to 8'h00 immediately, and no done pulse appears.
  - A new request with amt=2 after reset release returns the correct result.
